// File: rtl/sort_serializer.sv
// rtl/sort_serializer.sv - serializes a captured 5-word sorted frame, flags ordering faults and counts dropped frames
module sort_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_index,
    output logic             out_last,
    output logic             out_order_err,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] slot0, slot1, slot2, slot3, slot4;
    logic [2:0]       idx;
    logic             err_q;
    logic             order_bad;

    // Equal neighbours are legal; only a strictly larger successor is a fault.
    assign order_bad = (in1 < in2) | (in2 < in3) | (in3 < in4) | (in4 < in5);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            idx        <= 3'd0;
            err_q      <= 1'b0;
            drop_count <= '0;
        end else begin
            if (in_valid && !in_ready && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= SEND;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        idx       <= 3'd0;
                        err_q     <= order_bad;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == 3'd4) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            idx       <= 3'd0;
                            err_q     <= 1'b0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    idx       <= 3'd0;
                    err_q     <= 1'b0;
                end
            endcase
        end
    end

    // Payload slots carry no reset; out_data is gated by out_valid so stale words never leak.
    always_ff @(posedge clk) begin
        if (!rst && (state == IDLE) && in_valid) begin
            slot0 <= in1;
            slot1 <= in2;
            slot2 <= in3;
            slot3 <= in4;
            slot4 <= in5;
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (idx)
                3'd0:    out_data = slot0;
                3'd1:    out_data = slot1;
                3'd2:    out_data = slot2;
                3'd3:    out_data = slot3;
                3'd4:    out_data = slot4;
                default: out_data = '0;
            endcase
        end
    end

    assign out_index     = idx;
    assign out_last      = out_valid && (idx == 3'd4);
    assign out_order_err = err_q;

endmodule

// File: doc/sort_serializer.md
SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of each sample word.
REQ-002 SHALL have parameter CNT_W, default 8: width of the dropped-frame counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: a sorted 5-word frame is present on in1..in5.
REQ-006 SHALL have ports in1..in5  input  WIDTH each: the frame from the upstream sorter, nominally non-increasing (in1 largest).
REQ-007 SHALL have port in_ready  output  1: registered; block can accept a frame this cycle.
REQ-008 SHALL have port out_data  output  WIDTH: current serial word.
REQ-009 SHALL have port out_valid  output  1: out_data is valid.
REQ-010 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-011 SHALL have port out_index  output  3: position 0..4 of the current word within its frame.
REQ-012 SHALL have port out_last  output  1: high with out_valid when out_index==4.
REQ-013 SHALL have port out_order_err  output  1: current frame was not non-increasing; held for all 5 words of that frame.
REQ-014 SHALL have port drop_count  output  CNT_W: number of frames offered while in_ready was low.

Function
REQ-015 SHALL implement two states: IDLE (in_ready=1, out_valid=0) and SEND (in_ready=0, out_valid=1).
REQ-016 SHALL accept a frame when in_valid && in_ready at a posedge, capture in1..in5 into buffer slots 0..4, set out_index=0, and enter SEND.
REQ-017 SHALL present buffer slot 0 on out_data with out_valid=1 in the cycle immediately after acceptance (latency 1 cycle).
REQ-018 SHALL advance out_index by 1 and present the next slot on each posedge where out_valid && out_ready.
REQ-019 SHALL hold out_data, out_index, out_last and out_order_err stable while out_valid && !out_ready.
REQ-020 SHALL, on the handshake with out_index==4, return to IDLE: out_valid=0, out_last=0, out_index=0, and in_ready=1 in the next cycle.
REQ-021 SHALL NOT accept a new frame in the cycle the last word completes; the earliest next acceptance is the following cycle (minimum 6 cycles per frame).
REQ-022 SHALL compute out_order_err at capture as OR over k=1..4 of (in_k < in_(k+1)), unsigned compare; equal adjacent values are not an error.
REQ-023 SHALL increment drop_count on every posedge where in_valid && !in_ready, saturating at 2^CNT_W-1 with no wrap.
REQ-024 SHALL leave the buffer and the current frame unaffected by dropped frames.
REQ-025 SHALL drive out_data=0 whenever out_valid=0.

Reset
REQ-026 SHALL, when rst=1 at a posedge, set state IDLE, in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, out_order_err=0, drop_count=0.
REQ-027 SHALL abort any in-progress frame on reset mid-SEND; buffered words are discarded, never emitted.
REQ-028 SHALL give rst priority over in_valid and out_ready in the same cycle; no frame is accepted and no count is taken.

Verification
REQ-029 SHALL cover: frame 900,700,500,300,100 with out_ready=1 -> words 900,700,500,300,100 on 5 consecutive cycles starting 1 cycle after accept, out_index 0..4, out_last only on 100, out_order_err=0.
REQ-030 SHALL cover: same frame, out_ready low for 3 cycles at index 2 -> out_data=500 and out_index=2 held all 3 cycles, no words lost or duplicated.
REQ-031 SHALL cover: frame 5,9,3,3,1 -> out_order_err=1 on all 5 words; frame 8,8,8,8,8 -> out_order_err=0.
REQ-032 SHALL cover: in_valid held high continuously during SEND for 4 busy cycles -> drop_count=4, emitted frame unchanged; with CNT_W=2 and 5 drops -> drop_count=3.
REQ-033 SHALL cover: rst pulsed while out_index==2 -> next cycle out_valid=0, in_ready=1, drop_count=0; a new frame 40,30,20,10,0 then emits from index 0.
REQ-034 SHALL cover: in_valid held high across a frame boundary -> the next frame is accepted exactly 1 cycle after the out_last handshake, with no drop counted in the acceptance cycle.
